// File: rtl/up_frame_checker.sv
// ---------------------------------------------------------------------------
// up_frame_checker
//
// Consumes the burst stream of the four-channel round-robin FIFO readout
// stage and checks each packet:
//   w0 = {HEAD, channel}, w1 = sequence number, then PAYLOAD_WORDS payload words.
// The payload is forwarded with a channel tag, one status record is
// reported per packet, and good/error packet counters are kept.
//
// Handshake: there is no backpressure. data_valid qualifies up_data on
// every rising clk edge. pay_valid qualifies pay_data/pay_chan/pay_last for
// exactly one cycle. pkt_done qualifies the status outputs, which hold
// their values until the next pkt_done.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   data_valid      burst qualifier; high for the whole packet
//   up_data[63:0]   packet word
//   pay_valid       forwarded payload word valid (1-cycle latency)
//   pay_data[63:0]  forwarded payload word
//   pay_chan[2:0]   channel of the forwarded word
//   pay_last        payload word number PAYLOAD_WORDS
//   pkt_done        one-cycle end-of-packet pulse
//   pkt_ok, hdr_err, seq_err, len_err, pkt_chan[2:0]   packet status
//   good_cnt[31:0]  packets passed (wraps)
//   err_cnt[15:0]   packets failed (saturates)
// ---------------------------------------------------------------------------
module up_frame_checker #(
    parameter int          PAYLOAD_WORDS = 128,
    parameter logic [31:0] HEAD          = 32'hADF90C00,
    parameter int          NUM_CH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_valid,
    input  logic [63:0] up_data,
    output logic        pay_valid,
    output logic [63:0] pay_data,
    output logic [2:0]  pay_chan,
    output logic        pay_last,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic        hdr_err,
    output logic        seq_err,
    output logic        len_err,
    output logic [2:0]  pkt_chan,
    output logic [31:0] good_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [15:0] PAY_LEN = 16'(PAYLOAD_WORDS);
    localparam logic [31:0] MAX_CH  = 32'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_SEQ, S_PAY, S_DROP} state_t;

    // state_q is kept as a plain named register so checkers can bind to it.
    state_t      state_q;
    logic        prev_valid_q;
    logic [2:0]  chan_q;
    logic [15:0] cnt_q;
    logic        hdr_f_q;
    logic        seq_f_q;
    logic        len_f_q;
    logic [63:0] last_seq_q [0:NUM_CH];

    logic        rise;
    logic        hdr_good;
    logic        seq_bad;
    logic        fin_len;
    logic        fin_ok;

    assign rise     = data_valid && !prev_valid_q;
    assign hdr_good = (up_data[63:32] == HEAD) && (up_data[31:0] != 32'd0) &&
                      (up_data[31:0] <= MAX_CH);
    assign seq_bad  = (up_data != (last_seq_q[chan_q] + 64'd1));

    // End-of-packet length verdict. A packet that ends while still in SEQ has
    // no payload at all; DROP is not length-checked since hdr_err covers it.
    assign fin_len  = len_f_q || (state_q == S_SEQ) ||
                      ((state_q == S_PAY) && (cnt_q != PAY_LEN));
    assign fin_ok   = !(hdr_f_q || seq_f_q || fin_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            // Pretend valid was already high so a burst in flight at reset
            // release is ignored until a fresh rising edge.
            prev_valid_q <= 1'b1;
            chan_q       <= '0;
            cnt_q        <= '0;
            hdr_f_q      <= 1'b0;
            seq_f_q      <= 1'b0;
            len_f_q      <= 1'b0;
            for (int i = 0; i <= NUM_CH; i++) begin
                last_seq_q[i] <= '0;
            end
            pay_valid    <= 1'b0;
            pay_data     <= '0;
            pay_chan     <= '0;
            pay_last     <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_ok       <= 1'b0;
            hdr_err      <= 1'b0;
            seq_err      <= 1'b0;
            len_err      <= 1'b0;
            pkt_chan     <= '0;
            good_cnt     <= '0;
            err_cnt      <= '0;
        end else begin
            prev_valid_q <= data_valid;
            pay_valid    <= 1'b0;
            pay_last     <= 1'b0;
            pkt_done     <= 1'b0;

            if ((state_q != S_IDLE) && !data_valid) begin
                // Packet finished: publish status and reset per-packet state.
                pkt_done <= 1'b1;
                pkt_ok   <= fin_ok;
                hdr_err  <= hdr_f_q;
                seq_err  <= seq_f_q;
                len_err  <= fin_len;
                pkt_chan <= hdr_f_q ? 3'd0 : chan_q;
                if (fin_ok) begin
                    good_cnt <= good_cnt + 32'd1;
                end else if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                hdr_f_q <= 1'b0;
                seq_f_q <= 1'b0;
                len_f_q <= 1'b0;
                cnt_q   <= '0;
                chan_q  <= '0;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rise) begin
                            if (hdr_good) begin
                                chan_q  <= up_data[2:0];
                                state_q <= S_SEQ;
                            end else begin
                                hdr_f_q <= 1'b1;
                                state_q <= S_DROP;
                            end
                        end
                    end
                    S_SEQ: begin
                        // Always resync to the received number.
                        seq_f_q            <= seq_bad;
                        last_seq_q[chan_q] <= up_data;
                        state_q            <= S_PAY;
                    end
                    S_PAY: begin
                        if (cnt_q < PAY_LEN) begin
                            pay_valid <= 1'b1;
                            pay_data  <= up_data;
                            pay_chan  <= chan_q;
                            pay_last  <= (cnt_q == PAY_LEN - 16'd1);
                            cnt_q     <= cnt_q + 16'd1;
                        end else begin
                            len_f_q <= 1'b1;
                        end
                    end
                    S_DROP: begin
                        // Consume words until valid drops.
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/up_frame_checker.md
# up_frame_checker

Downstream consumer of the four-channel round-robin FIFO readout stage. Parses its `data_valid`/`up_data` burst stream and checks every packet:
- header word, channel number, per-channel sequence number, payload length.

It forwards payload words with channel tags to the transport stage and reports per-packet status plus running good/error counters.

## Interface
Parameters:
- `PAYLOAD_WORDS`, 128, number of 64-bit payload words per packet.
- `HEAD`, 32'hADF90C00, required value of header word bits [63:32].
- `NUM_CH`, 4, highest legal channel number; legal channel numbers are 1..NUM_CH.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_valid`  in  1  burst qualifier from the readout stage; high for a whole packet.
- `up_data`  in  64  packet word.
- `pay_valid`  out  1  forwarded payload word valid.
- `pay_data`  out  64  forwarded payload word.
- `pay_chan`  out  3  channel of the forwarded word.
- `pay_last`  out  1  marks payload word number PAYLOAD_WORDS of the packet.
- `pkt_done`  out  1  one-cycle pulse at the end of each packet; qualifies the status outputs below.
- `pkt_ok`  out  1  packet passed all checks.
- `hdr_err`  out  1  header mismatch or illegal channel.
- `seq_err`  out  1  sequence number is not last+1 for that channel.
- `len_err`  out  1  wrong burst length.
- `pkt_chan`  out  3  channel of the finished packet; 0 if the header was bad.
- `good_cnt`  out  32  count of packets with pkt_ok=1; wraps.
- `err_cnt`  out  16  count of packets with pkt_ok=0; saturates at 16'hFFFF.

## Operation
Packet format, one burst of consecutive `data_valid=1` cycles:
- w0 = {HEAD, 32-bit channel}.
- w1 = 64-bit sequence number.
- w2..w(PAYLOAD_WORDS+1) = payload.
- Correct burst length is PAYLOAD_WORDS+2.

Delimiting:
- A packet starts on a sampled 0->1 transition of `data_valid`.
- It ends on the first sampled 0. Any drop of `data_valid` ends the packet.
- Packets may be separated by a single idle cycle.

State machine:
- IDLE: wait for a valid rising edge. The first valid word is w0:
  - if [63:32]==HEAD and [31:0] is in 1..NUM_CH: latch channel, go to SEQ;
  - otherwise: set hdr_err, go to DROP.
- SEQ: w1 is compared with last_seq[ch]+1 (64-bit, wraps).
  - Mismatch sets seq_err.
  - last_seq[ch] is always loaded with the received value (resync).
  - Go to PAY.
- PAY: forward each word and increment the 16-bit payload counter.
  - Word number PAYLOAD_WORDS is forwarded with pay_last=1.
  - Words beyond PAYLOAD_WORDS are not forwarded; they set len_err.
- DROP: consume words and forward nothing.
- Leaving SEQ, PAY or DROP: when valid is sampled 0 in any of these states, go to IDLE.
  - Set len_err if the state is SEQ, or if the payload count is not equal to PAYLOAD_WORDS. The len check is skipped in DROP because hdr_err already covers it.
  - Emit pkt_done. pkt_ok = no error flag set.
  - Update good_cnt or err_cnt.
  - Clear the error flags and counter for the next packet.

Counter and flag rules:
- last_seq[1..NUM_CH] reset to 0, so the first packet per channel must carry sequence 1.
- A short packet does not generate pay_last. The downstream stage uses pkt_done plus len_err to discard it.
- Status outputs hold their values until the next pkt_done.

Reset:
- Reset forces IDLE with the internal previous-valid register set to 1.
- If `data_valid` is high when reset is released, the remainder of that burst is ignored until valid goes low and rises again.
- Reset mid-packet discards the packet with no pkt_done.

Reset values:
- All outputs 0.
- last_seq all 0.

## Timing
- Payload forwarding latency is 1 cycle: a word sampled at edge k appears on pay_* after edge k, with pay_valid high for exactly that cycle.
- pkt_done is asserted for the cycle following the edge that samples `data_valid`=0. The status outputs and updated counters are valid in that same cycle.
- With a single idle gap, pkt_done of packet N and the w0 capture of packet N+1 occur on adjacent edges with no interference.
- Throughput is one word per cycle, with no backpressure.

## Test plan
1. Reset, then four packets for channels 1..4, each with seq=1 and 128 incrementing payload words, gap 7 cycles:
   - 128 pay_valid per packet, pay_last on the 128th, pay_data equal to input delayed 1 cycle;
   - four pkt_done with pkt_ok=1, good_cnt=4, err_cnt=0.
2. Second packet on channel 2 with seq=3 after a seq=1 packet:
   - seq_err=1, pkt_ok=0, err_cnt=1;
   - a following packet with seq=4 passes.
3. Header 32'hADF90C01 or channel 5:
   - hdr_err=1, pkt_chan=0, no pay_valid, err_cnt increments.
4. Burst of 100 words, then a burst of 140 words:
   - first: len_err=1, no pay_last, 98 payload words forwarded;
   - second: len_err=1, exactly 128 forwarded with pay_last on the 128th.
5. Packets separated by one idle cycle:
   - both checked correctly, two pkt_done pulses 131 cycles apart.
6. rst_n asserted at payload word 60 and released while valid is still high:
   - no pkt_done, no further pay_valid until the next rising edge;
   - the next packet with seq=1 passes.
